fu_issue_ctrl: RTL and testbench



---
 rtl/fu_issue_ctrl_pkg.sv | 21 ++
 rtl/fu_issue_ctrl_watchdog.sv | 35 +++
 rtl/fu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fu_issue_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_ctrl_pkg.sv
// Shared definitions for the multi-cycle FU issue controller: state
// encoding, default widths and the watchdog counter sizing helper.
package fu_issue_ctrl_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RA_W_DEF    = 5;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } fu_state_e;

    // Counter must hold 0..timeout-1; keep at least one bit for tiny values.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/fu_issue_ctrl_watchdog.sv
// Clearable saturating up-counter; expired_o flags the last allowed
// cycle of a wait window so the owner can abandon the operation.
module fu_watchdog
    import fu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = wd_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles since the last clear, holding at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fu_issue_ctrl.sv
// Issue-side initiator for EN/finish style multi-cycle FUs: launches one
// op at a time, captures the result and hands it to writeback.
module fu_issue_ctrl
    import fu_issue_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RA_W    = RA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] issue_A,
    input  logic [XLEN-1:0] issue_B,
    input  logic [RA_W-1:0] issue_rd,
    output logic            fu_EN,
    output logic [XLEN-1:0] fu_A,
    output logic [XLEN-1:0] fu_B,
    input  logic [XLEN-1:0] fu_res,
    input  logic            fu_finish,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RA_W-1:0] wb_rd,
    output logic            busy,
    output logic [RA_W-1:0] busy_rd,
    output logic            timeout_err
);

    fu_state_e       state_q;
    logic            issue_ready_q;
    logic            fu_en_q;
    logic [XLEN-1:0] fu_a_q;
    logic [XLEN-1:0] fu_b_q;
    logic            wb_valid_q;
    logic [XLEN-1:0] wb_data_q;
    logic [RA_W-1:0] wb_rd_q;
    logic            busy_q;
    logic [RA_W-1:0] busy_rd_q;
    logic            timeout_err_q;
    logic            wd_expired_s;

    fu_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_START),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired_s)
    );

    // Issue FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            issue_ready_q <= 1'b0;
            fu_en_q       <= 1'b0;
            fu_a_q        <= '0;
            fu_b_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            busy_q        <= 1'b0;
            busy_rd_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_valid && issue_ready_q) begin
                        state_q       <= ST_START;
                        issue_ready_q <= 1'b0;
                        fu_en_q       <= 1'b1;
                        fu_a_q        <= issue_A;
                        fu_b_q        <= issue_B;
                        busy_q        <= 1'b1;
                        busy_rd_q     <= issue_rd;
                    end else begin
                        issue_ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    fu_en_q <= 1'b0;
                end
                ST_WAIT: begin
                    // A finish in the expiry cycle still counts as success.
                    if (fu_finish) begin
                        state_q    <= ST_WB;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= fu_res;
                        wb_rd_q    <= busy_rd_q;
                    end else if (wd_expired_s) begin
                        state_q       <= ST_IDLE;
                        timeout_err_q <= 1'b1;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        busy_rd_q     <= '0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state_q       <= ST_IDLE;
                        wb_valid_q    <= 1'b0;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        busy_rd_q     <= '0;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    issue_ready_q <= 1'b0;
                    fu_en_q       <= 1'b0;
                    wb_valid_q    <= 1'b0;
                    busy_q        <= 1'b0;
                    busy_rd_q     <= '0;
                end
            endcase
        end
    end

    assign issue_ready = issue_ready_q;
    assign fu_EN       = fu_en_q;
    assign fu_A        = fu_a_q;
    assign fu_B        = fu_b_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign busy        = busy_q;
    assign busy_rd     = busy_rd_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl: the FU is emulated cycle by cycle
// from the stimulus thread, with hand-computed expectations.
module tb_fu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_A, issue_B;
    logic [4:0]  issue_rd;
    logic        fu_EN;
    logic [31:0] fu_A, fu_B, fu_res;
    logic        fu_finish;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        busy;
    logic [4:0]  busy_rd;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    fu_issue_ctrl #(.XLEN(32), .RA_W(5), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_A(issue_A), .issue_B(issue_B), .issue_rd(issue_rd),
        .fu_EN(fu_EN), .fu_A(fu_A), .fu_B(fu_B),
        .fu_res(fu_res), .fu_finish(fu_finish),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd),
        .busy(busy), .busy_rd(busy_rd), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op in an IDLE cycle T; returns in T+1 with fu_EN checked.
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        chk("ready_before_issue", {31'd0, issue_ready}, 32'd1);
        issue_valid = 1'b1; issue_A = a; issue_B = b; issue_rd = rd;
        tick();
        issue_valid = 1'b0;
        chk("fu_en_t1", {31'd0, fu_EN}, 32'd1);
        chk("fu_a", fu_A, a);
        chk("fu_b", fu_B, b);
        chk("busy_rd", {27'd0, busy_rd}, {27'd0, rd});
        chk("ready_start", {31'd0, issue_ready}, 32'd0);
    endtask

    // From T+1, pulse finish in T+1+lat; returns in T+2+lat.
    task automatic finish_after(input int lat, input logic [31:0] res);
        for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) chk("fu_en_single", {31'd0, fu_EN}, 32'd0);
            chk("no_wb_early", {31'd0, wb_valid}, 32'd0);
        end
        fu_finish = 1'b1; fu_res = res;
        tick();
        fu_finish = 1'b0; fu_res = 32'h0BAD_F00D;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_A = 32'd0; issue_B = 32'd0;
        issue_rd = 5'd0; fu_res = 32'd0; fu_finish = 1'b0; wb_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", {31'd0, issue_ready}, 32'd0);
        chk("rst_en", {31'd0, fu_EN}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, issue_ready}, 32'd1);

        // Basic multiply, L=7: wb_valid in T+9, ready again in T+10.
        issue_op(32'd3, 32'd5, 5'd7);
        finish_after(7, 32'd15);
        chk("basic_wbv", {31'd0, wb_valid}, 32'd1);
        chk("basic_data", wb_data, 32'd15);
        chk("basic_rd", {27'd0, wb_rd}, 32'd7);
        tick();
        chk("basic_ready", {31'd0, issue_ready}, 32'd1);
        chk("basic_idle", {31'd0, busy}, 32'd0);
        chk("basic_busy_rd", {27'd0, busy_rd}, 32'd0);

        // Backpressure for 5 cycles.
        wb_ready = 1'b0;
        issue_op(32'd6, 32'd7, 5'd9);
        finish_after(7, 32'd42);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wbv", {31'd0, wb_valid}, 32'd1);
            chk("bp_data", wb_data, 32'd42);
            chk("bp_rd", {27'd0, wb_rd}, 32'd9);
            chk("bp_ready", {31'd0, issue_ready}, 32'd0);
            if (i < 4) tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("bp_release_ready", {31'd0, issue_ready}, 32'd1);
        chk("bp_release_wbv", {31'd0, wb_valid}, 32'd0);

        // Timeout: 15 WAIT cycles (T+2..T+16), error visible in T+17.
        issue_op(32'd1, 32'd1, 5'd4);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("to_no_err", {31'd0, timeout_err}, 32'd0);
        end
        tick();
        chk("to_busy_last", {31'd0, busy}, 32'd1);
        chk("to_err_last", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_ready", {31'd0, issue_ready}, 32'd1);
        chk("to_wbv", {31'd0, wb_valid}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);

        // Race: finish in the expiry cycle (T+16).
        do_reset();
        chk("rst_clears_err", {31'd0, timeout_err}, 32'd0);
        issue_op(32'd2, 32'd2, 5'd11);
        finish_after(15, 32'hDEAD_BEEF);
        chk("race_wbv", {31'd0, wb_valid}, 32'd1);
        chk("race_data", wb_data, 32'hDEAD_BEEF);
        chk("race_err", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("race_done", {31'd0, issue_ready}, 32'd1);

        // Reset mid-WAIT, then a stale finish in IDLE.
        issue_op(32'd8, 32'd8, 5'd13);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_fu_a", fu_A, 32'd0);
        tick();
        rst = 1'b0;
        fu_finish = 1'b1; fu_res = 32'h1234_5678;
        tick();
        fu_finish = 1'b0;
        tick();
        chk("stale_wbv", {31'd0, wb_valid}, 32'd0);
        chk("stale_busy", {31'd0, busy}, 32'd0);
        chk("stale_busy_rd", {27'd0, busy_rd}, 32'd0);
        issue_op(32'd10, 32'd20, 5'd21);
        finish_after(3, 32'd200);
        chk("post_rst_data", wb_data, 32'd200);
        chk("post_rst_rd", {27'd0, wb_rd}, 32'd21);
        tick();

        // Issue held valid while busy: second op accepted in IDLE.
        issue_op(32'd2, 32'd4, 5'd3);
        issue_valid = 1'b1; issue_A = 32'd9; issue_B = 32'd11; issue_rd = 5'd12;
        tick();
        chk("hold_ready_wait", {31'd0, issue_ready}, 32'd0);
        chk("hold_fu_a", fu_A, 32'd2);
        chk("hold_busy_rd", {27'd0, busy_rd}, 32'd3);
        tick();
        fu_finish = 1'b1; fu_res = 32'd8;
        tick();
        fu_finish = 1'b0;
        chk("hold_wb_data", wb_data, 32'd8);
        chk("hold_wb_rd", {27'd0, wb_rd}, 32'd3);
        tick();
        chk("hold_idle_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("hold_second_en", {31'd0, fu_EN}, 32'd1);
        chk("hold_second_a", fu_A, 32'd9);
        chk("hold_second_b", fu_B, 32'd11);
        chk("hold_second_rd", {27'd0, busy_rd}, 32'd12);
        finish_after(1, 32'd99);
        chk("hold_second_data", wb_data, 32'd99);
        chk("hold_second_wbrd", {27'd0, wb_rd}, 32'd12);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
